// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, one outstanding imem request.
// FETCH_COMPRESSED_EN: allows halfword PCs and 16-bit instructions.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instValid,
  input  logic        instReady,
  output logic [31:0] instData,
  output logic [31:0] instPc,
  output logic [31:0] instPcLink,
  output logic        fetchFault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_data;
  logic [31:0] r_ipc;
  logic [31:0] r_link;
  logic        r_discard;
  logic        r_reqValid;
  logic        r_instValid;
  logic        r_fault;

  logic        w_misaligned;
  logic        w_is16;
  logic [31:0] w_data;
  logic [31:0] w_link;

`ifdef FETCH_COMPRESSED_EN
  assign w_misaligned = redirectTarget[0];
  assign w_is16       = (imemRespData[1:0] != 2'b11);
`else
  assign w_misaligned = |redirectTarget[1:0];
  assign w_is16       = 1'b0;
`endif

  // Word presented to decode, and the link of the instruction at pc
  assign w_data = w_is16 ? {16'h0000, imemRespData[15:0]} : imemRespData;
  assign w_link = r_pc + (w_is16 ? 32'd2 : 32'd4);

  // Fetch FSM; redirect outranks every other event in the cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_discard   <= 1'b0;
      r_reqValid  <= 1'b0;
      r_instValid <= 1'b0;
      r_fault     <= 1'b0;
      r_data      <= 32'h0;
      r_ipc       <= 32'h0;
      r_link      <= 32'h0;
    end else if (redirectValid && w_misaligned) begin
      r_state     <= S_FAULT;
      r_reqValid  <= 1'b0;
      r_instValid <= 1'b0;
      r_fault     <= 1'b1;
    end else if (redirectValid) begin
      r_pc        <= redirectTarget;
      r_instValid <= 1'b0;
      r_fault     <= 1'b0;
      r_state     <= S_REQ;
      r_reqValid  <= 1'b1;
      unique case (r_state)
        S_REQ: begin
          if (imemReqReady) begin
            r_state    <= S_WAIT;
            r_reqValid <= 1'b0;
            r_discard  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imemRespValid) begin
            r_discard <= 1'b0;
          end else begin
            r_state    <= S_WAIT;
            r_reqValid <= 1'b0;
            r_discard  <= 1'b1;
          end
        end
        S_FAULT: begin
          if (imemRespValid) r_discard <= 1'b0;
        end
        default: ;
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_reqValid <= 1'b1;
        end
        S_REQ: begin
          if (imemReqReady) begin
            r_state    <= S_WAIT;
            r_reqValid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imemRespValid) begin
            if (r_discard) begin
              r_discard  <= 1'b0;
              r_state    <= S_REQ;
              r_reqValid <= 1'b1;
            end else begin
              r_data      <= w_data;
              r_ipc       <= r_pc;
              r_link      <= w_link;
              r_state     <= S_OUT;
              r_instValid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (instReady) begin
            r_pc        <= r_link;
            r_state     <= S_REQ;
            r_instValid <= 1'b0;
            r_reqValid  <= 1'b1;
          end
        end
        S_FAULT: begin
          if (imemRespValid) r_discard <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imemReqValid = r_reqValid;
  assign imemReqAddr  = r_pc;
  assign instValid    = r_instValid;
  assign instData     = r_data;
  assign instPc       = r_ipc;
  assign instPcLink   = r_link;
  assign fetchFault   = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: flag-based reference model plus a
// latency-randomizing memory, directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReqValid;
  logic        imemReqReady = 1'b0;
  logic [31:0] imemReqAddr;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = 32'h0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = 32'h0;
  logic        instValid;
  logic        instReady = 1'b0;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic [31:0] instPcLink;
  logic        fetchFault;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .imemReqValid(imemReqValid),
    .imemReqReady(imemReqReady),
    .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid),
    .imemRespData(imemRespData),
    .redirectValid(redirectValid),
    .redirectTarget(redirectTarget),
    .instValid(instValid),
    .instReady(instReady),
    .instData(instData),
    .instPc(instPc),
    .instPcLink(instPcLink),
    .fetchFault(fetchFault)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Architectural rules
  function automatic bit misal(input logic [31:0] t);
`ifdef FETCH_COMPRESSED_EN
    return t[0];
`else
    return t[1:0] != 2'b00;
`endif
  endfunction

  function automatic bit is16(input logic [31:0] d);
`ifdef FETCH_COMPRESSED_EN
    return d[1:0] != 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] view(input logic [31:0] d);
    return is16(d) ? (d & 32'h0000_FFFF) : d;
  endfunction

  // Reference model: flags describing what fetch currently holds
  bit          m_started = 0;
  bit          m_fault = 0;
  bit          m_out = 0;
  bit          m_stale = 0;
  bit          m_have = 0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_data = 0;
  logic [31:0] m_ipc = 0;
  logic [31:0] m_link = 0;

  // Memory model
  bit          mem_pend = 0;
  int          mem_dly = 0;
  int          mem_dmin = 0;
  int          mem_max = 0;
  logic [31:0] mem_data = 0;
  bit          mem_fixed = 1;
  logic [31:0] mem_fixval = 32'h0000_0013;

  // Stimulus controls
  bit          s_rst = 1;
  bit          s_rv = 0;
  logic [31:0] s_tgt = 0;
  bit          s_rdy = 1;
  bit          s_irdy = 1;
  bit          s_ror = 0;
  logic [31:0] s_ror_tgt = 0;
  bit          s_rand = 0;

  int          cyc = 0;
  int          lq_cyc[$];
  logic [31:0] lq_addr[$];
  logic [31:0] li_pc[$];
  logic [31:0] li_link[$];

  function automatic bit exp_req();
    return m_started && !m_fault && !m_out && !m_have;
  endfunction

  function automatic logic [31:0] pick_tgt();
    logic [31:0] t;
    int r;
    r = $urandom_range(0, 7);
    t = $urandom & 32'h0000_0FFC;
    if (r == 0) t = 32'hFFFF_FFF8;
`ifdef FETCH_COMPRESSED_EN
    if (r == 1) t[1] = 1'b1;
    if (r == 2) t[0] = 1'b1;
`else
    if (r == 2) t[1:0] = 2'($urandom_range(1, 3));
`endif
    return t;
  endfunction

  task automatic model_step();
    bit acc;
    bit rsp;
    logic [31:0] d;
    acc = exp_req() && imemReqReady;
    rsp = imemRespValid;
    d = imemRespData;
    if (rsp) mem_pend = 0;
    if (acc) begin
      mem_pend = 1;
      mem_dly = $urandom_range(mem_dmin, mem_max);
      mem_data = mem_fixed ? mem_fixval : $urandom;
    end
    if (rst) begin
      m_started = 0; m_fault = 0; m_out = 0; m_stale = 0; m_have = 0;
      m_pc = RPC; m_data = 0; m_ipc = 0; m_link = 0;
    end else if (redirectValid && misal(redirectTarget)) begin
      m_started = 1; m_fault = 1; m_have = 0;
      if (acc) m_out = 1;
    end else if (redirectValid) begin
      m_started = 1; m_fault = 0; m_have = 0;
      m_pc = redirectTarget;
      if (acc) begin
        m_out = 1; m_stale = 1;
      end else if (m_out) begin
        if (rsp) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_fault) begin
      if (rsp) begin m_out = 0; m_stale = 0; end
    end else if (acc) begin
      m_out = 1;
    end else if (m_out) begin
      if (rsp) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin
          m_have = 1;
          m_data = view(d);
          m_ipc = m_pc;
          m_link = m_pc + (is16(d) ? 32'd2 : 32'd4);
        end
      end
    end else if (m_have && instReady) begin
      m_have = 0;
      m_pc = m_link;
    end
  endtask

  // One clock: compare at negedge, drive inputs, advance model at posedge
  task automatic cycle();
    @(negedge clk);
    cyc++;
    chk1("reqValid", imemReqValid, exp_req());
    chk("reqAddr", imemReqAddr, m_pc);
    chk1("instValid", instValid, m_have);
    chk1("fetchFault", fetchFault, m_fault);
    chk("instData", instData, m_data);
    chk("instPc", instPc, m_ipc);
    chk("instPcLink", instPcLink, m_link);
    if (imemReqValid) begin
      lq_cyc.push_back(cyc);
      lq_addr.push_back(imemReqAddr);
    end
    if (instValid) begin
      li_pc.push_back(instPc);
      li_link.push_back(instPcLink);
    end
    imemRespValid = 1'b0;
    imemRespData = $urandom;
    if (mem_pend) begin
      if (mem_dly == 0) begin
        imemRespValid = 1'b1;
        imemRespData = mem_data;
      end else begin
        mem_dly--;
      end
    end
    rst = s_rst;
    imemReqReady = s_rdy;
    instReady = s_irdy;
    redirectValid = s_rv;
    redirectTarget = s_tgt;
    if (s_rand) begin
      imemReqReady = ($urandom_range(0, 3) != 0);
      instReady = ($urandom_range(0, 2) != 0);
      redirectValid = ($urandom_range(0, 9) == 0);
      redirectTarget = pick_tgt();
    end
    if (s_ror && imemRespValid) begin
      redirectValid = 1'b1;
      redirectTarget = s_ror_tgt;
      s_ror = 0;
    end
    if (redirectValid && misal(redirectTarget) && imemRespValid)
      redirectValid = 1'b0;
    if (redirectValid && !misal(redirectTarget) && m_fault && mem_pend)
      redirectValid = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  task automatic clear_logs();
    lq_cyc.delete();
    lq_addr.delete();
    li_pc.delete();
    li_link.delete();
  endtask

  task automatic wait_inst();
    int k;
    k = 0;
    do begin
      cycle();
      #1;
      k++;
    end while (!instValid && k < 12);
    chk1("wait_inst", instValid, 1'b1);
  endtask

  task automatic do_reset();
    s_rst = 1;
    cycle();
    s_rst = 0;
    cyc = 0;
    clear_logs();
  endtask

  logic [31:0] bad_tgt;
  logic [31:0] exp_cdata;
  logic [31:0] exp_clink;
  int          nreq;

  initial begin
`ifdef FETCH_COMPRESSED_EN
    bad_tgt = 32'h0000_0201;
    exp_cdata = 32'h0000_4501;
    exp_clink = 32'h0000_0402;
`else
    bad_tgt = 32'h0000_0202;
    exp_cdata = 32'hABCD_4501;
    exp_clink = 32'h0000_0404;
`endif
    // Reset state
    s_rst = 1;
    cycle();
    cycle();
    #1;
    chk1("rst_reqValid", imemReqValid, 1'b0);
    chk("rst_reqAddr", imemReqAddr, 32'h100);
    chk1("rst_instValid", instValid, 1'b0);
    chk1("rst_fault", fetchFault, 1'b0);
    chk("rst_instData", instData, 32'h0);
    chk("rst_instPc", instPc, 32'h0);
    chk("rst_link", instPcLink, 32'h0);

    // Zero-wait streaming: requests on cycles 2, 5, 8
    s_rst = 0;
    cyc = 0;
    clear_logs();
    repeat (8) cycle();
    chk("t1_nreq", 32'(lq_cyc.size()), 32'd3);
    if (lq_cyc.size() >= 3) begin
      chk("t1_cyc0", 32'(lq_cyc[0]), 32'd2);
      chk("t1_cyc1", 32'(lq_cyc[1]), 32'd5);
      chk("t1_cyc2", 32'(lq_cyc[2]), 32'd8);
      chk("t1_addr0", lq_addr[0], 32'h100);
      chk("t1_addr1", lq_addr[1], 32'h104);
      chk("t1_addr2", lq_addr[2], 32'h108);
    end
    if (li_link.size() >= 1) chk("t1_link0", li_link[0], 32'h104);
    else chk("t1_ninst", 32'(li_link.size()), 32'd1);

    // Redirect coinciding with the response for 0x104
    do_reset();
    repeat (4) cycle();
    s_ror = 1;
    s_ror_tgt = 32'h200;
    repeat (3) cycle();
    chk("t2_nreq", 32'(lq_addr.size()), 32'd3);
    if (lq_addr.size() >= 3) begin
      chk("t2_addr", lq_addr[2], 32'h200);
      chk("t2_cyc", 32'(lq_cyc[2]), 32'd7);
    end

    // Decode stalls for 5 cycles in OUT
    s_irdy = 0;
    repeat (6) cycle();
    chk("t3_ninst", 32'(li_pc.size()), 32'd6);
    foreach (li_pc[i]) chk1("t3_no_stale", li_pc[i] == 32'h104, 1'b0);
    chk("t3_nreq", 32'(lq_addr.size()), 32'd3);
    #1;
    chk("t3_data", instData, 32'h13);
    chk("t3_pc", instPc, 32'h200);
    s_irdy = 1;
    cycle();
    s_rdy = 0;
    cycle();
    chk("t3_nreq2", 32'(lq_addr.size()), 32'd4);
    if (lq_addr.size() >= 4) begin
      chk("t3_next", lq_addr[3], 32'h204);
      chk("t3_cyc", 32'(lq_cyc[3]), 32'd15);
    end

    // Misaligned redirect faults; aligned redirect recovers
    s_rv = 1;
    s_tgt = bad_tgt;
    cycle();
    s_rv = 0;
    #1;
    chk1("t4_fault", fetchFault, 1'b1);
    chk1("t4_noreq", imemReqValid, 1'b0);
    s_rdy = 1;
    nreq = lq_addr.size();
    repeat (3) cycle();
    chk("t4_quiet", 32'(lq_addr.size()), 32'(nreq));
    s_rv = 1;
    s_tgt = 32'h300;
    cycle();
    s_rv = 0;
    #1;
    chk1("t4_clear", fetchFault, 1'b0);
    chk1("t4_req", imemReqValid, 1'b1);
    chk("t4_addr", imemReqAddr, 32'h300);

    // Compressed-candidate word at 0x400
    mem_fixval = 32'hABCD_4501;
    s_rv = 1;
    s_tgt = 32'h400;
    cycle();
    s_rv = 0;
    s_irdy = 0;
    wait_inst();
    chk("t5_data", instData, exp_cdata);
    chk("t5_pc", instPc, 32'h400);
    chk("t5_link", instPcLink, exp_clink);
    s_irdy = 1;
    cycle();
    s_irdy = 0;
    #1;
    chk1("t5_req", imemReqValid, 1'b1);
    chk("t5_next", imemReqAddr, exp_clink);

    // PC wrap at the top of the address space
    mem_fixval = 32'h0000_0013;
    s_rv = 1;
    s_tgt = 32'hFFFF_FFFC;
    cycle();
    s_rv = 0;
    wait_inst();
    chk("t6_pc", instPc, 32'hFFFF_FFFC);
    chk("t6_link", instPcLink, 32'h0);
    s_irdy = 1;
    cycle();
    #1;
    chk1("t6_req", imemReqValid, 1'b1);
    chk("t6_addr", imemReqAddr, 32'h0);

    // Reset while waiting; late response must be ignored
    mem_dmin = 3;
    mem_max = 3;
    s_rdy = 1;
    cycle();
    #1;
    chk1("t7_wait", imemReqValid, 1'b0);
    s_rdy = 0;
    s_rst = 1;
    cycle();
    cycle();
    #1;
    chk1("t7_rst_req", imemReqValid, 1'b0);
    chk("t7_rst_addr", imemReqAddr, 32'h100);
    chk("t7_rst_data", instData, 32'h0);
    s_rst = 0;
    repeat (3) cycle();
    #1;
    chk1("t7_req", imemReqValid, 1'b1);
    chk("t7_addr", imemReqAddr, 32'h100);
    chk1("t7_inst", instValid, 1'b0);
    chk("t7_data", instData, 32'h0);
    chk("t7_pc", instPc, 32'h0);
    chk("t7_link", instPcLink, 32'h0);
    chk1("t7_fault", fetchFault, 1'b0);

    // Random traffic against the model
    mem_dmin = 0;
    mem_max = 3;
    mem_fixed = 0;
    s_rdy = 1;
    s_rand = 1;
    repeat (4000) cycle();
    s_rand = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
